// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Client-side request/response bundle for sram_arbiter. Each field carries one
// slice per channel; channel c of a multi-bit field occupies [c*W +: W].
//   req_valid  per-channel request valid            (client -> arbiter)
//   req_ready  per-channel accept                   (arbiter -> client)
//   req_we     1 = write, 0 = read                  (client -> arbiter)
//   req_addr   NUM_CH*ADDR_W word addresses          (client -> arbiter)
//   req_wdata  NUM_CH*16 write data                  (client -> arbiter)
//   req_be     NUM_CH*2 byte enables, bit0 = low     (client -> arbiter)
//   rsp_valid  per-channel one-cycle completion      (arbiter -> client)
//   rsp_rdata  shared read data                      (arbiter -> client)
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 20
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*16-1:0]     req_wdata;
  logic [NUM_CH*2-1:0]      req_be;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [15:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Multi-channel arbiter/controller for a 16-bit asynchronous external SRAM.
// NUM_CH clients are served one access at a time (IDLE -> ACCESS -> RECOVER).
// The SRAM control pins are registered, so CE_N is low for exactly
// ACCESS_CYCLES clocks per access and always high for at least one clock
// between accesses (bus turnaround).
//
// Ports:
//   clk_clk          system clock, rising edge
//   reset_reset_n    asynchronous active-low reset; pins go inactive at once
//   bus              sram_arbiter_if.slave request/response bundle
//   busy             high whenever the controller is not idle
//   sram_wire_*      external SRAM address, data (inout) and strobes
//
// Build option:
//   SRAM_ARB_PRIORITY_EN  when defined, channel 0 always wins in IDLE and
//                         channels 1..NUM_CH-1 round-robin among themselves.
//                         When undefined, pure round-robin over all channels.
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int NUM_CH        = 2,
  parameter int ADDR_W        = 20,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  sram_arbiter_if.slave     bus,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_wire_ADDR,
  inout  wire  [15:0]       sram_wire_DQ,
  output logic              sram_wire_CE_N,
  output logic              sram_wire_OE_N,
  output logic              sram_wire_WE_N,
  output logic              sram_wire_LB_N,
  output logic              sram_wire_UB_N
);

  // Access lengths below one clock are treated as one clock.
  localparam int AC_EFF = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
  localparam int CNT_W  = (AC_EFF > 1) ? $clog2(AC_EFF) : 1;
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(AC_EFF - 1);
  // Starting at NUM_CH-1 makes channel 0 the first winner after reset.
  localparam logic [GW-1:0]    LAST_INIT = GW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t              state_r;
  logic [GW-1:0]       last_grant_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [15:0]         wdata_r;
  logic                we_r;
  logic                ce_n_r;
  logic                oe_n_r;
  logic                we_n_r;
  logic                lb_n_r;
  logic                ub_n_r;
  logic                dq_oe_r;
  logic                busy_r;
  logic [NUM_CH-1:0]   rsp_valid_r;
  logic [15:0]         rdata_r;

  logic [GW:0]         pick_s;
  logic                grant_vld_s;
  logic [GW-1:0]       grant_s;
  logic [NUM_CH-1:0]   ready_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [15:0]         sel_wdata_s;
  logic [1:0]          sel_be_s;

  // Round-robin search starting after 'last'; returns {found, index}.
  // With skip0 set, channel 0 is excluded from the rotation.
  function automatic logic [GW:0] rr_pick(
    input logic [NUM_CH-1:0] valid,
    input logic [GW-1:0]     last,
    input logic              skip0
  );
    logic          found;
    logic [GW-1:0] idx;
    int            c;
    found = 1'b0;
    idx   = {GW{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(last) + i) % NUM_CH;
      if (!found && valid[c] && !(skip0 && (c == 0))) begin
        found = 1'b1;
        idx   = GW'(c);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Grant selection among the currently valid requests.
  always_comb begin
    pick_s = {(GW+1){1'b0}};
`ifdef SRAM_ARB_PRIORITY_EN
    if (bus.req_valid[0]) begin
      pick_s = {1'b1, {GW{1'b0}}};
    end else begin
      pick_s = rr_pick(bus.req_valid, last_grant_r, 1'b1);
    end
`else
    pick_s = rr_pick(bus.req_valid, last_grant_r, 1'b0);
`endif
  end

  assign grant_vld_s = pick_s[GW];
  assign grant_s     = pick_s[GW-1:0];

  // Ready is offered only in IDLE, to the single granted channel.
  always_comb begin
    ready_s = {NUM_CH{1'b0}};
    if ((state_r == IDLE) && grant_vld_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = {NUM_CH{1'b0}};
    end
  end

  // Mux the granted channel's request fields.
  always_comb begin
    sel_we_s    = bus.req_we[grant_s];
    sel_addr_s  = bus.req_addr[grant_s*ADDR_W +: ADDR_W];
    sel_wdata_s = bus.req_wdata[grant_s*16 +: 16];
    sel_be_s    = bus.req_be[grant_s*2 +: 2];
  end

  // Controller FSM with registered SRAM pins and response outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_INIT;
      cnt_r        <= {CNT_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= 16'h0000;
      we_r         <= 1'b0;
      ce_n_r       <= 1'b1;
      oe_n_r       <= 1'b1;
      we_n_r       <= 1'b1;
      lb_n_r       <= 1'b1;
      ub_n_r       <= 1'b1;
      dq_oe_r      <= 1'b0;
      busy_r       <= 1'b0;
      rsp_valid_r  <= {NUM_CH{1'b0}};
      rdata_r      <= 16'h0000;
    end else begin
      rsp_valid_r <= {NUM_CH{1'b0}};
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
            we_r         <= sel_we_s;
            last_grant_r <= grant_s;
            cnt_r        <= CNT_LOAD;
            ce_n_r       <= 1'b0;
            we_n_r       <= ~sel_we_s;
            oe_n_r       <= sel_we_s;
            // Byte enables apply to writes only; reads use both lanes.
            lb_n_r       <= sel_we_s ? ~sel_be_s[0] : 1'b0;
            ub_n_r       <= sel_we_s ? ~sel_be_s[1] : 1'b0;
            dq_oe_r      <= sel_we_s;
            busy_r       <= 1'b1;
            state_r      <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            if (!we_r) begin
              rdata_r <= sram_wire_DQ;
            end else begin
              rdata_r <= rdata_r;
            end
            ce_n_r                    <= 1'b1;
            oe_n_r                    <= 1'b1;
            we_n_r                    <= 1'b1;
            lb_n_r                    <= 1'b1;
            ub_n_r                    <= 1'b1;
            dq_oe_r                   <= 1'b0;
            rsp_valid_r[last_grant_r] <= 1'b1;
            state_r                   <= RECOVER;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        RECOVER: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ce_n_r  <= 1'b1;
          oe_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          lb_n_r  <= 1'b1;
          ub_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_rdata  = rdata_r;
  assign busy           = busy_r;
  assign sram_wire_ADDR = addr_r;
  assign sram_wire_CE_N = ce_n_r;
  assign sram_wire_OE_N = oe_n_r;
  assign sram_wire_WE_N = we_n_r;
  assign sram_wire_LB_N = lb_n_r;
  assign sram_wire_UB_N = ub_n_r;
  // DQ is driven only during a write access; the enable clears on reset.
  assign sram_wire_DQ   = dq_oe_r ? wdata_r : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter (NUM_CH=3, ACCESS_CYCLES=2). Holds a
// pin-level SRAM model and a transaction-level reference (cycle offset since
// accept, grant rotation, reference memory) compared every cycle, plus
// directed scenarios with literal expectations. Honours SRAM_ARB_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 20;
  localparam int AC     = 2;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  always #5 clk_clk = ~clk_clk;

  sram_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  logic              busy;
  logic [ADDR_W-1:0] s_addr;
  wire  [15:0]       dq;
  logic              ce_n, oe_n, we_n, lb_n, ub_n;

  sram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .bus            (bus),
    .busy           (busy),
    .sram_wire_ADDR (s_addr),
    .sram_wire_DQ   (dq),
    .sram_wire_CE_N (ce_n),
    .sram_wire_OE_N (oe_n),
    .sram_wire_WE_N (we_n),
    .sram_wire_LB_N (lb_n),
    .sram_wire_UB_N (ub_n)
  );

  // Pin-level asynchronous SRAM: drives DQ while selected for a read.
  logic [15:0] pin_mem [0:4095];
  assign dq = (!ce_n && !oe_n && we_n) ? pin_mem[s_addr[11:0]] : 16'hzzzz;

  // Reference model state.
  logic [15:0]       ref_mem [0:4095];
  int                n_vec = 0;
  int                n_fail = 0;
  int                cyc = 0;
  int                m_k;
  int                m_last;
  int                m_g;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata;
  logic [1:0]        m_be;
  logic [15:0]       m_rdata;
  logic [15:0]       m_rd_pending;
  logic [NUM_CH-1:0] exp_ready;
  logic [NUM_CH-1:0] acc_mask;
  int                grant_q[$];
  int                acc_cyc_q[$];
  int                rsp_cyc;
  int                rsp_pulses;
  int                ce_low_cnt;
  logic [NUM_CH-1:0] rsp_mask_seen;
  logic              seen_lb0, seen_ub0, seen_we0, seen_oe0;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503 + 4660);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  // Next winner: first valid channel walking forward from last+1.
  function automatic int model_pick(input logic [NUM_CH-1:0] v, input int last);
    int ch;
`ifdef SRAM_ARB_PRIORITY_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      ch = (last + 1 + i) % NUM_CH;
`ifdef SRAM_ARB_PRIORITY_EN
      if (ch != 0 && v[ch]) return ch;
`else
      if (v[ch]) return ch;
`endif
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    m_last = NUM_CH - 1;
    m_rdata = 16'h0000;
  endtask

  // One clock: compare at negedge, then advance the model across the posedge.
  task automatic cycle();
    int g;
    @(negedge clk_clk);
    exp_ready = '0;
    if (m_k == 0) begin
      g = model_pick(bus.req_valid, m_last);
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("idle_ce_n", ce_n, 1);
      chk("idle_we_n", we_n, 1);
      chk("idle_oe_n", oe_n, 1);
      chk("idle_busy", busy, 0);
      chk("idle_rsp", bus.rsp_valid, 0);
    end else if (m_k <= AC) begin
      g = m_g;
      chk("acc_ce_n", ce_n, 0);
      chk("acc_we_n", we_n, !m_we);
      chk("acc_oe_n", oe_n, m_we);
      chk("acc_lb_n", lb_n, m_we ? !m_be[0] : 1'b0);
      chk("acc_ub_n", ub_n, m_we ? !m_be[1] : 1'b0);
      chk("acc_addr", s_addr, m_addr);
      if (m_we) chk("acc_dq", dq, m_wdata);
      chk("acc_busy", busy, 1);
      chk("acc_rsp", bus.rsp_valid, 0);
    end else begin
      g = m_g;
      chk("rec_pins", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
      chk("rec_busy", busy, 1);
      chk("rec_rsp", bus.rsp_valid, 1 << m_g);
    end
    chk("ready", bus.req_ready, exp_ready);
    chk("rdata", bus.rsp_rdata, m_rdata);
    acc_mask = exp_ready & bus.req_valid;
    if (!ce_n && !we_n)
      pin_mem[s_addr[11:0]] = merge(pin_mem[s_addr[11:0]], dq, {!ub_n, !lb_n});
    if (!ce_n) ce_low_cnt++;
    if (!ce_n && !lb_n) seen_lb0 = 1'b1;
    if (!ce_n && !ub_n) seen_ub0 = 1'b1;
    if (!ce_n && !we_n) seen_we0 = 1'b1;
    if (!ce_n && !oe_n) seen_oe0 = 1'b1;
    if (bus.rsp_valid != '0) begin
      rsp_cyc = cyc;
      rsp_mask_seen = bus.rsp_valid;
      rsp_pulses++;
    end
    @(posedge clk_clk);
    if (m_k == 0) begin
      if (acc_mask != '0) begin
        m_g     = g;
        m_last  = g;
        m_we    = bus.req_we[g];
        m_addr  = bus.req_addr[g*ADDR_W +: ADDR_W];
        m_wdata = bus.req_wdata[g*16 +: 16];
        m_be    = bus.req_be[g*2 +: 2];
        m_k     = 1;
        grant_q.push_back(g);
        acc_cyc_q.push_back(cyc);
        if (m_we) ref_mem[m_addr[11:0]] = merge(ref_mem[m_addr[11:0]], m_wdata, m_be);
        else m_rd_pending = ref_mem[m_addr[11:0]];
      end
    end else if (m_k == AC) begin
      m_k = AC + 1;
      if (!m_we) m_rdata = m_rd_pending;
    end else if (m_k == AC + 1) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_obs();
    ce_low_cnt = 0; rsp_pulses = 0; rsp_mask_seen = '0;
    seen_lb0 = 1'b0; seen_ub0 = 1'b0; seen_we0 = 1'b0; seen_oe0 = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    bus.req_valid[ch]                  = 1'b1;
    bus.req_we[ch]                     = we;
    bus.req_addr[ch*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[ch*16 +: 16]         = d;
    bus.req_be[ch*2 +: 2]              = be;
  endtask

  // Single transaction: hold valid until accepted, then wait for its response.
  task automatic issue(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    int budget;
    set_req(ch, we, a, d, be);
    budget = 0;
    do begin cycle(); budget++; end while (!acc_mask[ch] && budget < 40);
    chk("issue_accept", acc_mask[ch], 1);
    bus.req_valid[ch] = 1'b0;
    rsp_mask_seen = '0;
    budget = 0;
    while (rsp_mask_seen == '0 && budget < 40) begin cycle(); budget++; end
    chk("issue_rsp", rsp_mask_seen, 1 << ch);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk_clk);
    #1;
    chk("rst_pins", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
    chk("rst_addr", s_addr, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    reset_reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    for (int i = 0; i < 4096; i++) begin
      pin_mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    pin_mem[12'h123] = 16'hBEEF; ref_mem[12'h123] = 16'hBEEF;
    pin_mem[12'h010] = 16'h1234; ref_mem[12'h010] = 16'h1234;
    clear_obs();
    model_reset();
    do_reset();

    // Single read of 0xBEEF; be is ignored for reads.
    clear_obs();
    issue(0, 1'b0, 20'h00123, 16'h0000, 2'b01);
    chk("read_ce_cycles", ce_low_cnt, 2);
    chk("read_latency", rsp_cyc - acc_cyc_q[$], 3);
    chk("read_data", bus.rsp_rdata, 16'hBEEF);
    chk("read_oe_low", seen_oe0, 1);

    // Upper-byte write then readback.
    clear_obs();
    issue(1, 1'b1, 20'h00010, 16'hA55A, 2'b10);
    repeat (3) cycle();
    chk("bw_ub_low", seen_ub0, 1);
    chk("bw_lb_high", seen_lb0, 0);
    chk("bw_we_low", seen_we0, 1);
    chk("bw_rsp_once", rsp_pulses, 1);
    chk("bw_rdata_hold", bus.rsp_rdata, 16'hBEEF);
    issue(1, 1'b0, 20'h00010, 16'h0000, 2'b11);
    chk("bw_readback", bus.rsp_rdata, 16'hA534);

    // be=00 write: runs, acknowledges, changes nothing.
    clear_obs();
    issue(2, 1'b1, 20'h00300, 16'hFFFF, 2'b00);
    repeat (2) cycle();
    chk("be0_lb", seen_lb0, 0);
    chk("be0_ub", seen_ub0, 0);
    chk("be0_rsp", rsp_pulses, 1);
    issue(2, 1'b0, 20'h00300, 16'h0000, 2'b00);
    chk("be0_readback", bus.rsp_rdata, init_val(12'h300));

    // Reset during a write access.
    set_req(1, 1'b1, 20'h00FFF, 16'h5A5A, 2'b11);
    for (int b = 0; b < 10 && !acc_mask[1]; b++) cycle();
    bus.req_valid[1] = 1'b0;
    chk("mid_in_access", {ce_n, we_n}, 2'b00);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("mid_rst_pins", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
    chk("mid_rst_busy", busy, 0);
    repeat (2) begin
      @(posedge clk_clk); #1;
      chk("mid_rst_rsp", bus.rsp_valid, 0);
    end
    reset_reset_n = 1'b1;
    model_reset();
    clear_obs();
    repeat (4) cycle();
    chk("mid_no_rsp", rsp_pulses, 0);

    // Contention with every channel requesting continuously.
    do_reset();
    grant_q.delete(); acc_cyc_q.delete();
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b0, ADDR_W'(20'h00200 + c), 16'h0000, 2'b11);
`ifdef SRAM_ARB_PRIORITY_EN
    repeat (12) cycle();
    chk("prio_count", grant_q.size(), 3);
    for (int i = 0; i < grant_q.size(); i++) chk("prio_ch0", grant_q[i], 0);
    bus.req_valid[0] = 1'b0;
    grant_q.delete();
    repeat (8) cycle();
    chk("prio_count2", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("prio_next1", grant_q[0], 1);
      chk("prio_next2", grant_q[1], 2);
    end
`else
    repeat (24) cycle();
    chk("rr_count", grant_q.size(), 6);
    for (int i = 0; i < grant_q.size(); i++) chk("rr_order", grant_q[i], i % 3);
    for (int i = 1; i < acc_cyc_q.size(); i++) chk("rr_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 4);
`endif
    bus.req_valid = '0;
    repeat (6) cycle();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc_mask[c] || !bus.req_valid[c]) begin
          if ($urandom_range(0, 99) < 40)
            set_req(c, 1'($urandom_range(0, 1)), ADDR_W'(20'h00200 + $urandom_range(0, 15)),
                    16'($urandom), 2'($urandom_range(0, 3)));
          else
            bus.req_valid[c] = 1'b0;
        end else if ($urandom_range(0, 99) < 5) begin
          bus.req_valid[c] = 1'b0;
        end
      end
      cycle();
    end
    bus.req_valid = '0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
